regfile_storage: RTL and testbench

- Architectural storage for the ARM register file: 32 x 64-bit registers with a one-entry write-back staging register.
- Sits directly upstream of the 8:1/32:1 read-mux trees. It drives the committed register array to those trees.
- It also provides two forwarded read-data outputs, so a write still sitting in staging is visible to the next instruction.
- Register X31 (XZR) always reads zero and is never written.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/decoder5_32.sv | 18 +
 rtl/regfile_storage.sv | 89 ++++++++
 tb/tb_regfile_storage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizes and index/data types for the architectural register file.
package regfile_pkg;
    localparam int REG_W    = 64;
    localparam int NUM_REGS = 32;
    localparam int IDX_W    = 5;
    localparam int ZERO_REG = 31;

    typedef logic [REG_W-1:0] reg_t;
    typedef logic [IDX_W-1:0] ridx_t;
endpackage

// File: rtl/decoder5_32.sv
// 5:32 one-hot write-enable decoder, gated by en.
// Purely combinational; no backpressure.
module decoder5_32
    import regfile_pkg::*;
(
    input  ridx_t               idx,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_storage.sv
// 32x64 register array with a one-entry write-back stage and forwarded reads.
// Write visible in reg_q one edge after capture; reads are combinational; accepts a write every cycle.
module regfile_storage #(
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int WIDTH    = regfile_pkg::REG_W,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      RegWrite,
    input  logic [4:0]                WriteRegister,
    input  logic [WIDTH-1:0]          WriteData,
    input  logic [4:0]                ReadRegister1,
    input  logic [4:0]                ReadRegister2,
    output logic [NUM_REGS*WIDTH-1:0] reg_q,
    output logic [WIDTH-1:0]          ReadData1,
    output logic [WIDTH-1:0]          ReadData2,
    output logic                      wb_pending
);
    import regfile_pkg::*;

    localparam ridx_t ZERO_IDX = ridx_t'(ZERO_REG);

    logic                wb_valid;
    ridx_t               wb_addr;
    logic [WIDTH-1:0]    wb_data;
    logic [WIDTH-1:0]    regs [NUM_REGS];
    logic [NUM_REGS-1:0] wr_en;

    // Stage 1: X31 writes are dropped here so they never occupy staging.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= RegWrite && (WriteRegister != ZERO_IDX);
            wb_addr  <= WriteRegister;
            wb_data  <= WriteData;
        end
    end

    decoder5_32 u_dec (
        .idx    (wb_addr),
        .en     (wb_valid),
        .onehot (wr_en)
    );

    // Stage 2: commit; the zero register is never loaded, so it stays at its reset value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en[i] && (i != ZERO_REG)) begin
                    regs[i] <= wb_data;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*WIDTH +: WIDTH] = regs[g];
    end

    // A same-cycle RegWrite is deliberately not bypassed; only the staged write is.
    always_comb begin
        ReadData1 = regs[ReadRegister1];
        if (ReadRegister1 == ZERO_IDX) begin
            ReadData1 = '0;
        end else if (wb_valid && (wb_addr == ReadRegister1)) begin
            ReadData1 = wb_data;
        end
    end

    always_comb begin
        ReadData2 = regs[ReadRegister2];
        if (ReadRegister2 == ZERO_IDX) begin
            ReadData2 = '0;
        end else if (wb_valid && (wb_addr == ReadRegister2)) begin
            ReadData2 = wb_data;
        end
    end

    assign wb_pending = wb_valid;

endmodule

// File: tb/tb_regfile_storage.sv
// Directed self-checking bench for regfile_storage.
module tb_regfile_storage;

    logic          clk = 1'b0;
    logic          reset;
    logic          RegWrite;
    logic [4:0]    WriteRegister;
    logic [63:0]   WriteData;
    logic [4:0]    ReadRegister1;
    logic [4:0]    ReadRegister2;
    logic [2047:0] reg_q;
    logic [63:0]   ReadData1;
    logic [63:0]   ReadData2;
    logic          wb_pending;

    int n_cmp = 0;
    int n_err = 0;

    regfile_storage dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .reg_q         (reg_q),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .wb_pending    (wb_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] q(input int i);
        return reg_q[i*64 +: 64];
    endfunction

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] sweep_val(input int i);
        logic [63:0] pat;
        pat = 64'h0101_0101_0101_0101;
        if (i == 31) return 64'h0;
        return pat * 64'(i);
    endfunction

    initial begin
        reset = 1'b0;
        RegWrite = 1'b0;
        WriteRegister = '0;
        WriteData = '0;
        ReadRegister1 = 5'd3;
        ReadRegister2 = 5'd31;
        #2;
        check("rst_reg_q_zero", {63'h0, (reg_q == '0)}, 64'h1);
        check("rst_pending", {63'h0, wb_pending}, 64'h0);
        check("rst_rd1", ReadData1, 64'h0);
        step();
        reset = 1'b1;
        step();

        // Reset with a pending write to X3
        RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'hDEAD;
        step();
        RegWrite = 1'b0;
        check("pend_before_rst", {63'h0, wb_pending}, 64'h1);
        check("fwd_x3_before_rst", ReadData1, 64'hDEAD);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_reg_q_zero", {63'h0, (reg_q == '0)}, 64'h1);
        check("midrst_pending", {63'h0, wb_pending}, 64'h0);
        check("midrst_rd1", ReadData1, 64'h0);
        step();
        reset = 1'b1;
        step();
        check("postrst_x3_rd1", ReadData1, 64'h0);
        check("postrst_x3_q", q(3), 64'h0);

        // Write latency on X5
        ReadRegister1 = 5'd5;
        RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 64'h1234_5678_9ABC_DEF0;
        step();
        RegWrite = 1'b0;
        check("lat_pending", {63'h0, wb_pending}, 64'h1);
        check("lat_fwd_x5", ReadData1, 64'h1234_5678_9ABC_DEF0);
        check("lat_q_x5_early", q(5), 64'h0);
        step();
        check("lat_q_x5", q(5), 64'h1234_5678_9ABC_DEF0);
        check("lat_pending_clr", {63'h0, wb_pending}, 64'h0);
        check("lat_rd1_x5", ReadData1, 64'h1234_5678_9ABC_DEF0);

        // Zero register write is dropped
        ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
        RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        RegWrite = 1'b0;
        check("xzr_pending", {63'h0, wb_pending}, 64'h0);
        check("xzr_rd1", ReadData1, 64'h0);
        check("xzr_rd2", ReadData2, 64'h0);
        step();
        check("xzr_q", q(31), 64'h0);

        // Back-to-back writes to X7
        ReadRegister1 = 5'd7; ReadRegister2 = 5'd7;
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h1;
        step();
        WriteData = 64'h2;
        check("b2b_fwd1", ReadData1, 64'h1);
        check("b2b_q_first", q(7), 64'h0);
        step();
        RegWrite = 1'b0;
        check("b2b_fwd2", ReadData1, 64'h2);
        check("b2b_fwd2_p2", ReadData2, 64'h2);
        check("b2b_q_mid", q(7), 64'h1);
        step();
        check("b2b_q_last", q(7), 64'h2);
        check("b2b_pending_clr", {63'h0, wb_pending}, 64'h0);

        // Read-before-write on X9
        ReadRegister1 = 5'd9;
        RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 64'hA;
        step();
        RegWrite = 1'b0;
        step();
        RegWrite = 1'b1; WriteData = 64'hB;
        #1;
        check("rbw_before_edge", ReadData1, 64'hA);
        step();
        RegWrite = 1'b0;
        check("rbw_after_edge", ReadData1, 64'hB);
        step();
        check("rbw_q", q(9), 64'hB);

        // Sweep all registers, then read every pair on both ports
        for (int i = 0; i < 31; i++) begin
            RegWrite = 1'b1; WriteRegister = 5'(i); WriteData = sweep_val(i);
            step();
        end
        RegWrite = 1'b0;
        WriteRegister = 5'd31;
        step();
        for (int i = 0; i < 32; i++) begin
            check($sformatf("sweep_q_x%0d", i), q(i), sweep_val(i));
        end
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                ReadRegister1 = 5'(a);
                ReadRegister2 = 5'(b);
                #1;
                check($sformatf("sweep_rd1_x%0d", a), ReadData1, sweep_val(a));
                check($sformatf("sweep_rd2_x%0d", b), ReadData2, sweep_val(b));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
